// File: rtl/reg_file_mp.sv
// reg_file_mp: register file with two registered read ports, one general
// write port and one link write port (jump-and-link).
// After reset, a CLEAR sequence zeroes one entry per cycle. Accesses are
// accepted once the sequence has finished.
// Optional macro REG_FILE_BYPASS_EN: a read returns the data being written
// at the same edge. Without it, such a read returns the value held before
// the write.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rd_valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_we,
  input  logic [DATA_W-1:0] link_data,
  output logic              busy
);
  localparam int                DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_we, w_link_we;
  logic [DATA_W-1:0] w_rs1_nxt, w_rs2_nxt;

  // Effective write strobes. Address 0 is hard-wired to zero, so writes to it are dropped.
  assign w_we      = (r_state == READY) && we && (wr_addr != '0);
  assign w_link_we = (r_state == READY) && link_we && (LINK_A != '0);
  assign busy      = (r_state == CLEAR);

  // Next state: leave CLEAR once the last entry has been zeroed.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == CLEAR && r_cnt == '1) w_state_nxt = READY;
  end

  // State register and clear counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Storage. The link write is issued last, so it wins a collision on LINK_REG.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == CLEAR) begin
        r_mem[r_cnt] <= '0;
      end else begin
        if (w_we)      r_mem[wr_addr] <= wr_data;
        if (w_link_we) r_mem[LINK_A]  <= link_data;
      end
    end
  end

  // Read data for the next output edge. Optional same-edge write forwarding applies, with the link write taking priority.
  always_comb begin
    w_rs1_nxt = r_mem[rs1_addr];
    w_rs2_nxt = r_mem[rs2_addr];
`ifdef REG_FILE_BYPASS_EN
    if (w_we && rs1_addr == wr_addr)      w_rs1_nxt = wr_data;
    if (w_link_we && rs1_addr == LINK_A)  w_rs1_nxt = link_data;
    if (w_we && rs2_addr == wr_addr)      w_rs2_nxt = wr_data;
    if (w_link_we && rs2_addr == LINK_A)  w_rs2_nxt = link_data;
`endif
    if (rs1_addr == '0) w_rs1_nxt = '0;
    if (rs2_addr == '0) w_rs2_nxt = '0;
  end

  // Registered read ports. The data outputs hold their values when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rs1_data <= '0;
      rs2_data <= '0;
    end else if (r_state == READY && rd_en) begin
      rd_valid <= 1'b1;
      rs1_data <= w_rs1_nxt;
      rs2_data <= w_rs2_nxt;
    end else begin
      rd_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and random checks of reg_file_mp against an
// array-based model. A second instance covers the small-parameter build.
module tb_reg_file_mp;
  logic        clk = 1'b0;
  logic        rst, rd_en, we, link_we, busy, rd_valid;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr;
  logic [31:0] wr_data, link_data, rs1_data, rs2_data;

  logic        s_rst, s_rd_en, s_we, s_link_we, s_busy, s_rd_valid;
  logic [2:0]  s_rs1, s_rs2, s_wa;
  logic [15:0] s_wd, s_ld, s_rs1_data, s_rs2_data;

  int checks = 0, failures = 0;
  logic [31:0] m [32];
  logic [31:0] h1, h2;

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_valid(rd_valid), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .link_we(link_we), .link_data(link_data),
    .busy(busy)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(3), .LINK_REG(7)) dut_s (
    .clk(clk), .rst(s_rst), .rd_en(s_rd_en), .rs1_addr(s_rs1), .rs2_addr(s_rs2),
    .rs1_data(s_rs1_data), .rs2_data(s_rs2_data), .rd_valid(s_rd_valid), .we(s_we),
    .wr_addr(s_wa), .wr_data(s_wd), .link_we(s_link_we), .link_data(s_ld),
    .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 0; we = 0; link_we = 0;
  endtask

  // One READY cycle: the model applies the writes and predicts the read result.
  task automatic tick(input string tag);
    logic [31:0] nm [32];
    logic [31:0] e1, e2;
    logic        r;
    nm = m;
    if (we && wr_addr != 0) nm[wr_addr] = wr_data;
    if (link_we) nm[31] = link_data;
`ifdef REG_FILE_BYPASS_EN
    e1 = nm[rs1_addr]; e2 = nm[rs2_addr];
`else
    e1 = m[rs1_addr];  e2 = m[rs2_addr];
`endif
    if (rs1_addr == 0) e1 = 0;
    if (rs2_addr == 0) e2 = 0;
    r = rd_en;
    m = nm;
    step();
    if (r) begin h1 = e1; h2 = e2; end
    chk({tag, ".valid"}, 32'(rd_valid), 32'(r));
    chk({tag, ".rs1"}, rs1_data, h1);
    chk({tag, ".rs2"}, rs2_data, h2);
  endtask

  // Drive through a clear sequence with junk accesses and count the busy cycles.
  task automatic run_clear(input string tag);
    int n;
    n = 0;
    rst = 0; we = 1; wr_addr = 5; wr_data = 32'h1234_5678;
    link_we = 1; link_data = 32'h9999; rd_en = 1; rs1_addr = 5; rs2_addr = 31;
    do begin
      step(); n++;
      if (rd_valid !== 1'b0) chk({tag, ".valid_in_clear"}, 32'(rd_valid), 32'd0);
    end while (busy && n < 100);
    chk({tag, ".clear_cycles"}, n, 32'd32);
    idle();
    foreach (m[i]) m[i] = 0;
  endtask

  initial begin
    rst = 1; idle(); rs1_addr = 0; rs2_addr = 0; wr_addr = 0; wr_data = 0; link_data = 0;
    s_rst = 1; s_rd_en = 0; s_we = 0; s_link_we = 0; s_rs1 = 0; s_rs2 = 0; s_wa = 0; s_wd = 0; s_ld = 0;
    h1 = 0; h2 = 0;
    step(); step();
    chk("reset.busy", 32'(busy), 32'd1);
    chk("reset.valid", 32'(rd_valid), 32'd0);
    chk("reset.rs1", rs1_data, 32'd0);
    chk("reset.rs2", rs2_data, 32'd0);

    run_clear("clr");

    // Every register reads zero after the clear sequence.
    for (int i = 0; i < 32; i++) begin
      rd_en = 1; rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      tick("zero");
    end

    idle(); we = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; tick("w5");
    idle(); rd_en = 1; rs1_addr = 5; rs2_addr = 0; tick("rd5");
    idle(); tick("hold");

    idle(); we = 1; wr_addr = 31; wr_data = 32'h11; link_we = 1; link_data = 32'h40; tick("coll31");
    idle(); we = 1; wr_addr = 3; wr_data = 32'h22; link_we = 1; link_data = 32'h40; tick("coll3");
    idle(); rd_en = 1; rs1_addr = 31; rs2_addr = 3; tick("rdcoll");
    chk("coll.r31", rs1_data, 32'h40);
    chk("coll.r3", rs2_data, 32'h22);

    idle(); we = 1; wr_addr = 7; wr_data = 32'hAAAA; tick("w7");
    idle(); we = 1; wr_addr = 7; wr_data = 32'h5555; rd_en = 1; rs1_addr = 7; rs2_addr = 7; tick("same_edge");
`ifdef REG_FILE_BYPASS_EN
    chk("same_edge.lit", rs1_data, 32'h5555);
`else
    chk("same_edge.lit", rs1_data, 32'hAAAA);
`endif

    idle(); we = 1; wr_addr = 0; wr_data = 32'hFFFF_FFFF; rd_en = 1; rs1_addr = 0; rs2_addr = 0; tick("w0");
    idle(); rd_en = 1; rs1_addr = 0; rs2_addr = 7; tick("rd0");

    for (int i = 0; i < 300; i++) begin
      rd_en = 1'($urandom); we = 1'($urandom); link_we = ($urandom_range(0, 3) == 0);
      rs1_addr = 5'($urandom); rs2_addr = 5'($urandom); wr_addr = 5'($urandom);
      wr_data = $urandom; link_data = $urandom;
      if (i % 4 == 0) rs1_addr = wr_addr;
      if (i % 5 == 0) rs2_addr = 31;
      tick("rand");
    end

    // Reset asserted partway through a clear restarts it from address 0.
    idle(); rst = 1; step(); rst = 0;
    for (int i = 0; i < 10; i++) step();
    chk("midclr.busy", 32'(busy), 32'd1);
    rst = 1; step();
    h1 = 0; h2 = 0;
    chk("midclr.rs1_reset", rs1_data, 32'd0);
    run_clear("clr2");
    idle(); rd_en = 1; rs1_addr = 5; rs2_addr = 31; tick("after_clr2");

    // Small-parameter instance.
    begin
      int n;
      n = 0;
      s_rst = 0; s_we = 1; s_wa = 6; s_wd = 16'h0BAD; s_rd_en = 1;
      do begin step(); n++; end while (s_busy && n < 100);
      chk("small.clear_cycles", n, 32'd8);
      s_we = 1; s_wa = 6; s_wd = 16'hFFFF; s_rd_en = 0; s_link_we = 1; s_ld = 16'h1234; step();
      s_we = 0; s_link_we = 0; s_rd_en = 1; s_rs1 = 6; s_rs2 = 7; step();
      chk("small.valid", 32'(s_rd_valid), 32'd1);
      chk("small.r6", 32'(s_rs1_data), 32'h0000FFFF);
      chk("small.r7", 32'(s_rs2_data), 32'h00001234);
      s_rd_en = 1; s_rs1 = 1; s_rs2 = 0; step();
      chk("small.r1", 32'(s_rs1_data), 32'd0);
      s_rd_en = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
